// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the FSM state enum, datapath select encodings and the instruction
// field codes (op, cmd, cond) used by the controller and condition checker.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // op field
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // data-processing cmd field
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // condition field
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// ARM condition-code evaluator (combinational).
// Ports: cond[3:0] instruction condition field, flags[3:0] NZCV,
//        CondEx = 1 when the instruction should take effect.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    CondEx = 1'b1;
    case (cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      default: CondEx = 1'b1;  // AL and 1111
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Main control FSM for the multicycle ARM core: sequences fetch/decode/
// execute/memory/writeback and owns the NZCV flags and per-instruction condition.
// Ports: clk, rst_n, Instr[31:12], ALUFlags in; write enables, datapath
//        selects, ImmSrc/RegSrc/ALUControl, Flags and debug State out.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   Flags,
  output logic [3:0]   State
);

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic        cond_q;
  logic        cond_ex;

  logic [1:0]  op;
  logic        i_bit, s_bit;
  logic [3:0]  cmd, rd;
  logic        unused_rn;

  assign op        = Instr[27:26];
  assign i_bit     = Instr[25];
  assign cmd       = Instr[24:21];
  assign s_bit     = Instr[20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  cond_check u_cond_check (
    .cond   (Instr[31:28]),
    .flags  (flags_q),
    .CondEx (cond_ex)
  );

  // ALU operation and whether the command writes a destination register
  logic [1:0] alu_ctl;
  logic       dp_wr;
  always_comb begin
    alu_ctl = 2'b00;
    dp_wr   = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_ctl = 2'b00; dp_wr = 1'b1; end
      CMD_SUB: begin alu_ctl = 2'b01; dp_wr = 1'b1; end
      CMD_AND: begin alu_ctl = 2'b10; dp_wr = 1'b1; end
      CMD_ORR: begin alu_ctl = 2'b11; dp_wr = 1'b1; end
      CMD_CMP: begin alu_ctl = 2'b01; dp_wr = 1'b0; end
      default: begin alu_ctl = 2'b00; dp_wr = 1'b0; end
    endcase
  end

  // Flags are written on the last edge of EXECR/EXECI; CMP always sets them.
  logic flag_en, flag_all, flag_nz;
  assign flag_en  = ((state_q == EXECR) || (state_q == EXECI)) && cond_q &&
                    (s_bit || (cmd == CMD_CMP));
  assign flag_all = flag_en && ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP));
  assign flag_nz  = flag_en && ((cmd == CMD_AND) || (cmd == CMD_ORR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flag_all)
        flags_q <= ALUFlags;
      else if (flag_nz)
        flags_q <= {ALUFlags[3:2], flags_q[1:0]};
      // Condition is frozen for the rest of the instruction
      if (state_q == DECODE)
        cond_q <= cond_ex;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_d = i_bit ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = s_bit ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  logic pcw_raw, mw_raw, rw_raw, irw_raw;
  always_comb begin
    pcw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    irw_raw    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw_raw    = cond_q;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mw_raw = cond_q;
      end
      EXECR: ALUControl = alu_ctl;
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_ctl;
      end
      ALUWB: begin
        rw_raw  = cond_q & dp_wr;
        pcw_raw = cond_q & (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        pcw_raw   = cond_q;
      end
      default: ;
    endcase
  end

  // Reset holds the FSM in FETCH, whose PC/IR writes must not fire.
  assign PCWrite  = pcw_raw & rst_n;
  assign MemWrite = mw_raw  & rst_n;
  assign RegWrite = rw_raw  & rst_n;
  assign IRWrite  = irw_raw & rst_n;

  assign ImmSrc = op;
  assign RegSrc = {(op == OP_MEM), (op == OP_BR)};
  assign Flags  = flags_q;
  assign State  = state_q;

endmodule
